// File: rtl/counter_pkg.sv
// Shared types for the parametrised event counter: terminal modes and
// run-control states.
package counter_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    WRAP    = 2'b00,
    SAT     = 2'b01,
    ONESHOT = 2'b10,
    RSVD    = 2'b11
  } cnt_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } cnt_state_e;

endpackage

// File: rtl/counter_n.sv
// Up/down event counter with runtime terminal value, synchronous load and
// wrap / saturate / one-shot terminal behaviour under an IDLE-RUN-DONE FSM.
module counter_n
  import counter_pkg::*;
#(
  parameter int                WIDTH    = 8,
  parameter logic [MODE_W-1:0] DEF_MODE = 2'b00
) (
  input  logic              Clk,
  input  logic              Rst_N,
  input  logic              Start_Pe,
  input  logic              Load,
  input  logic [WIDTH-1:0]  Load_Val,
  input  logic              En_Cnt,
  input  logic              Up_Dn,
  input  logic [WIDTH-1:0]  Term_Val,
  input  logic [MODE_W-1:0] Mode,
  output logic [WIDTH-1:0]  Cnt_Out,
  output logic              CO,
  output logic              TC_Evt,
  output logic              Busy,
  output logic              Done
);

  cnt_state_e       state, state_nxt;
  cnt_mode_e        mode_eff;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             mode_live;
  logic             at_term;
  logic             step;
  logic             busy_q, done_q;

  // DEF_MODE governs only until the first clock after reset; from then on
  // the Mode input is used directly so a change takes effect that cycle.
  assign mode_eff = mode_live ? cnt_mode_e'(Mode) : cnt_mode_e'(DEF_MODE);

  assign at_term = Up_Dn ? (cnt >= Term_Val) : (cnt == '0);
  assign step    = (state == RUN) & En_Cnt & ~Start_Pe & ~Load;

  assign CO      = at_term;
  assign TC_Evt  = step & at_term;
  assign Cnt_Out = cnt;
  assign Busy    = busy_q;
  assign Done    = done_q;

  always_comb begin
    cnt_nxt = cnt;
    if (Start_Pe) begin
      cnt_nxt = Up_Dn ? '0 : Term_Val;
    end else if (Load) begin
      cnt_nxt = (Up_Dn && (Load_Val > Term_Val)) ? Term_Val : Load_Val;
    end else if (step) begin
      if (at_term) begin
        case (mode_eff)
          SAT, ONESHOT: cnt_nxt = cnt;
          default:      cnt_nxt = Up_Dn ? '0 : Term_Val;
        endcase
      end else begin
        cnt_nxt = Up_Dn ? (cnt + WIDTH'(1)) : (cnt - WIDTH'(1));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (Start_Pe || Load) state_nxt = RUN;
      RUN:        if (TC_Evt && (mode_eff == ONESHOT)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      cnt       <= '0;
      mode_live <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      mode_live <= 1'b1;
    end
  end

  // Busy/Done are registered copies of the next state so they align with it.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_counter_n.sv
// Self-checking bench for counter_n: an 8-bit and a 4-bit instance share
// stimulus and are checked every cycle against an arithmetic model.
module tb_counter_n;

  logic       Clk;
  logic       Rst_N;
  logic       Start_Pe;
  logic       Load;
  logic [7:0] Load_Val;
  logic       En_Cnt;
  logic       Up_Dn;
  logic [7:0] Term_Val;
  logic [1:0] Mode;

  logic [7:0] cnt8;
  logic [3:0] cnt4;
  logic [1:0] dco, dtc, dbusy, ddone;

  int nChecks = 0;
  int nFails  = 0;

  int mw[2] = '{8, 4};
  int mcnt[2];
  bit mrun[2];
  bit mdone[2];

  counter_n #(.WIDTH(8), .DEF_MODE(2'b00)) dut8 (
    .Clk(Clk), .Rst_N(Rst_N), .Start_Pe(Start_Pe), .Load(Load),
    .Load_Val(Load_Val), .En_Cnt(En_Cnt), .Up_Dn(Up_Dn),
    .Term_Val(Term_Val), .Mode(Mode), .Cnt_Out(cnt8), .CO(dco[0]),
    .TC_Evt(dtc[0]), .Busy(dbusy[0]), .Done(ddone[0])
  );

  counter_n #(.WIDTH(4), .DEF_MODE(2'b00)) dut4 (
    .Clk(Clk), .Rst_N(Rst_N), .Start_Pe(Start_Pe), .Load(Load),
    .Load_Val(Load_Val[3:0]), .En_Cnt(En_Cnt), .Up_Dn(Up_Dn),
    .Term_Val(Term_Val[3:0]), .Mode(Mode), .Cnt_Out(cnt4), .CO(dco[1]),
    .TC_Evt(dtc[1]), .Busy(dbusy[1]), .Done(ddone[1])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit mCo(input int i);
    int tv;
    tv = int'(Term_Val) % (1 << mw[i]);
    return Up_Dn ? (mcnt[i] >= tv) : (mcnt[i] == 0);
  endfunction

  function automatic bit mTc(input int i);
    return mrun[i] && En_Cnt && mCo(i) && !Start_Pe && !Load;
  endfunction

  // Reference behaviour expressed as plain integer arithmetic per width.
  always @(posedge Clk or negedge Rst_N) begin
    int tv, lv, md;
    bit co;
    if (!Rst_N) begin
      for (int i = 0; i < 2; i++) begin
        mcnt[i]  <= 0;
        mrun[i]  <= 1'b0;
        mdone[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        md = 1 << mw[i];
        tv = int'(Term_Val) % md;
        lv = int'(Load_Val) % md;
        co = mCo(i);
        if (Start_Pe) begin
          mcnt[i] <= Up_Dn ? 0 : tv;
          mrun[i] <= 1'b1; mdone[i] <= 1'b0;
        end else if (Load) begin
          mcnt[i] <= Up_Dn ? ((lv < tv) ? lv : tv) : lv;
          mrun[i] <= 1'b1; mdone[i] <= 1'b0;
        end else if (mrun[i] && En_Cnt) begin
          if (co) begin
            if (Mode == 2'd2) begin
              mrun[i] <= 1'b0; mdone[i] <= 1'b1;
            end else if (Mode != 2'd1) begin
              mcnt[i] <= Up_Dn ? 0 : tv;
            end
          end else begin
            mcnt[i] <= (mcnt[i] + (Up_Dn ? 1 : md - 1)) % md;
          end
        end
      end
    end
  end

  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("cnt%0d", i), (i == 0) ? int'(cnt8) : int'(cnt4), mcnt[i]);
      checkOutput($sformatf("co%0d", i), int'(dco[i]), int'(mCo(i)));
      checkOutput($sformatf("tc%0d", i), int'(dtc[i]), int'(mTc(i)));
      checkOutput($sformatf("busy%0d", i), int'(dbusy[i]), int'(mrun[i]));
      checkOutput($sformatf("done%0d", i), int'(ddone[i]), int'(mdone[i]));
    end
  end

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_N = 1'b0; Start_Pe = 1'b0; Load = 1'b0; Load_Val = 8'd0;
    En_Cnt = 1'b1; Up_Dn = 1'b1; Term_Val = 8'd255; Mode = 2'b00;
    applyStimulus(2);
    checkOutput("rst_cnt", int'(cnt8), 0);
    checkOutput("rst_busy", int'(dbusy[0]), 0);
    checkOutput("rst_done", int'(ddone[0]), 0);
    Rst_N = 1'b1;

    // IDLE ignores En_Cnt
    applyStimulus(10);
    checkOutput("idle_cnt", int'(cnt8), 0);
    checkOutput("idle_co_up", int'(dco[0]), 0);
    Up_Dn = 1'b0;
    #1;
    checkOutput("idle_co_dn", int'(dco[0]), 1);
    checkOutput("idle_tc", int'(dtc[0]), 0);

    // legacy 8-bit wrap
    En_Cnt = 1'b0; Up_Dn = 1'b1; Start_Pe = 1'b1;
    applyStimulus(1);
    Start_Pe = 1'b0;
    checkOutput("wrap_start", int'(cnt8), 0);
    checkOutput("wrap_busy", int'(dbusy[0]), 1);
    En_Cnt = 1'b1;
    applyStimulus(255);
    checkOutput("wrap_255", int'(cnt8), 255);
    checkOutput("wrap_co", int'(dco[0]), 1);
    checkOutput("wrap_tc", int'(dtc[0]), 1);
    applyStimulus(1);
    checkOutput("wrap_0", int'(cnt8), 0);
    checkOutput("wrap_co_low", int'(dco[0]), 0);
    checkOutput("model_wrap8", mcnt[0], 0);
    checkOutput("model_wrap4", mcnt[1], 0);

    // 4-bit saturate at 9
    En_Cnt = 1'b0; Term_Val = 8'd9; Mode = 2'b01; Start_Pe = 1'b1;
    applyStimulus(1);
    Start_Pe = 1'b0; En_Cnt = 1'b1;
    applyStimulus(9);
    checkOutput("sat_9", int'(cnt4), 9);
    checkOutput("sat_co", int'(dco[1]), 1);
    checkOutput("sat_tc", int'(dtc[1]), 1);
    applyStimulus(3);
    checkOutput("sat_hold", int'(cnt4), 9);
    checkOutput("sat_busy", int'(dbusy[1]), 1);
    checkOutput("model_sat", mcnt[1], 9);

    // down one-shot from 5
    En_Cnt = 1'b0; Up_Dn = 1'b0; Term_Val = 8'd5; Mode = 2'b10; Start_Pe = 1'b1;
    applyStimulus(1);
    Start_Pe = 1'b0;
    checkOutput("os_start", int'(cnt8), 5);
    En_Cnt = 1'b1;
    applyStimulus(5);
    checkOutput("os_zero", int'(cnt8), 0);
    checkOutput("os_tc", int'(dtc[0]), 1);
    checkOutput("os_done_pre", int'(ddone[0]), 0);
    applyStimulus(1);
    checkOutput("os_done", int'(ddone[0]), 1);
    checkOutput("os_busy", int'(dbusy[0]), 0);
    applyStimulus(3);
    checkOutput("os_hold", int'(cnt8), 0);
    checkOutput("os_tc_off", int'(dtc[0]), 0);
    Start_Pe = 1'b1;
    applyStimulus(1);
    Start_Pe = 1'b0;
    checkOutput("os_restart", int'(cnt8), 5);
    checkOutput("os_rebusy", int'(dbusy[0]), 1);

    // priority, clamping, lowered terminal
    En_Cnt = 1'b0; Up_Dn = 1'b1; Term_Val = 8'd20; Mode = 2'b00;
    Load = 1'b1; Load_Val = 8'd50;
    applyStimulus(1);
    Load = 1'b0;
    checkOutput("clamp8", int'(cnt8), 20);
    checkOutput("clamp_co", int'(dco[0]), 1);
    checkOutput("clamp4", int'(cnt4), 2);
    Start_Pe = 1'b1; Load = 1'b1; En_Cnt = 1'b1;
    applyStimulus(1);
    Start_Pe = 1'b0; Load = 1'b0;
    checkOutput("prio_start", int'(cnt8), 0);
    applyStimulus(10);
    En_Cnt = 1'b0;
    checkOutput("prio_10", int'(cnt8), 10);
    Term_Val = 8'd3;
    #1;
    checkOutput("lower_co", int'(dco[0]), 1);
    checkOutput("lower_tc_off", int'(dtc[0]), 0);
    En_Cnt = 1'b1;
    #1;
    checkOutput("lower_tc", int'(dtc[0]), 1);
    applyStimulus(1);
    En_Cnt = 1'b0;
    checkOutput("lower_wrap", int'(cnt8), 0);

    // async reset mid-count
    Term_Val = 8'd255; Load_Val = 8'h79; Load = 1'b1;
    applyStimulus(1);
    Load = 1'b0; En_Cnt = 1'b1;
    applyStimulus(1);
    checkOutput("pre_rst", int'(cnt8), 8'h7A);
    #2;
    Rst_N = 1'b0;
    #1;
    checkOutput("arst_cnt", int'(cnt8), 0);
    checkOutput("arst_busy", int'(dbusy[0]), 0);
    checkOutput("arst_done", int'(ddone[0]), 0);
    checkOutput("model_arst", mcnt[0], 0);
    applyStimulus(1);
    Rst_N = 1'b1;
    applyStimulus(5);
    checkOutput("post_rst_idle", int'(cnt8), 0);
    Start_Pe = 1'b1;
    applyStimulus(1);
    Start_Pe = 1'b0;
    applyStimulus(3);
    checkOutput("post_rst_run", int'(cnt8), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/counter_n.md
Name: counter_n

Overview:
Parametrised successor of the controller's 8-bit event counter. Adds generic width, a runtime terminal value, up/down counting, synchronous load, and three terminal modes (wrap, saturate, one-shot) under a small run-control FSM. It sits beside the controller and returns the count, a terminal-count flag and a done flag.

Parameters:
WIDTH, 8, counter width in bits (legal range 2..32)
DEF_MODE, 2'b00, mode sampled at reset; runtime Mode input overrides it after reset

Ports:
Clk  input  1  system clock, rising edge
Rst_N  input  1  asynchronous, active-low reset
Start_Pe  input  1  synchronous clear plus arm; highest priority
Load  input  1  synchronous load of Load_Val
Load_Val  input  WIDTH  load value
En_Cnt  input  1  count enable
Up_Dn  input  1  1 = count up, 0 = count down
Term_Val  input  WIDTH  terminal value when counting up; reload value when counting down
Mode  input  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 reserved (treated as WRAP)
Cnt_Out  output  WIDTH  registered count
CO  output  1  combinational; count is at terminal for the current direction
TC_Evt  output  1  combinational one-cycle strobe; a counting step was taken while at terminal
Busy  output  1  registered; FSM in RUN
Done  output  1  registered; FSM in DONE

Behaviour:
- Reset (Rst_N low, asynchronous):
  - Cnt_Out = 0, state = IDLE, Busy = 0, Done = 0.
  - Mode register = DEF_MODE.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on Start_Pe or Load.
  - RUN -> DONE when Mode = ONESHOT and TC_Evt.
  - DONE -> RUN on Start_Pe or Load.
  - There is no other exit from RUN.
- Priority each cycle: Start_Pe > Load > En_Cnt > hold.
- Start_Pe: Cnt_Out <= 0 if Up_Dn = 1, else Term_Val. State goes to RUN.
- Load: Cnt_Out <= min(Load_Val, Term_Val) when Up_Dn = 1; Load_Val unclamped when Up_Dn = 0. State goes to RUN.
- Counting happens only in RUN with En_Cnt high. In IDLE and DONE, En_Cnt is ignored and the count holds.
- Terminal condition:
  - Up: Cnt_Out >= Term_Val (>= covers Term_Val lowered mid-count).
  - Down: Cnt_Out == 0.
- CO = terminal condition, in any state.
- TC_Evt = (state == RUN) & En_Cnt & CO & ~Start_Pe & ~Load.
- Next count for a counting step that is not at terminal: Cnt_Out ± 1, modulo 2^WIDTH. The arithmetic never produces a carry or borrow beyond WIDTH.
- Next count at terminal (TC_Evt):
  - WRAP: up -> 0, down -> Term_Val.
  - SAT: hold.
  - ONESHOT: hold and enter DONE.
- Term_Val = 0 while counting up: terminal every cycle. WRAP holds at 0 with TC_Evt each enabled cycle.
- Up_Dn may change on any cycle; it takes effect on the same cycle, with no pipeline.
- Mode is sampled every cycle. Changing Mode mid-RUN is legal and takes effect immediately.
- Start_Pe and Load together: Start_Pe wins and Load is discarded.
- Reset mid-count: all state clears immediately, without waiting for Clk.
- Latency: one cycle from any control input to Cnt_Out. CO and TC_Evt are combinational from the registers and inputs.
- Backward compatibility: WIDTH = 8, Term_Val = 255, Up_Dn = 1, Mode = WRAP, with one Start_Pe after reset, behaves like the legacy 8-bit counter with CO = (count == 255).

Decomposition:
- Shared package counter_pkg:
  - cnt_mode_e enum: WRAP, SAT, ONESHOT, RSVD.
  - cnt_state_e enum: IDLE, RUN, DONE.
  - localparam MODE_W = 2.
- Single module; no sub-module is warranted. The next-count logic is one combinational block feeding the count register. The FSM is a separate always_ff with its own next-state block.

Test Plan:
- WIDTH = 8, Term_Val = 255, up, WRAP; reset, Start_Pe, then 256 En_Cnt cycles -> Cnt_Out 0..255 then 0; CO high only at 255; TC_Evt single pulse on the step 255 -> 0.
- WIDTH = 4, Term_Val = 9, up, SAT; 12 enabled cycles -> Cnt_Out holds at 9; CO stays high from cycle 9; TC_Evt high on cycles 10, 11 and 12; Busy stays 1.
- WIDTH = 8, Term_Val = 5, down, ONESHOT; Start_Pe -> Cnt_Out = 5; after 5 steps Cnt_Out = 0; the next step raises TC_Evt and gives Done = 1, Busy = 0 one cycle later; further En_Cnt keeps Cnt_Out at 0; Start_Pe -> back to 5, RUN.
- Priority and clamping, Term_Val = 20, up:
  - Load_Val = 50 with Load -> Cnt_Out = 20, CO = 1.
  - Start_Pe with Load and En_Cnt on the same cycle -> Cnt_Out = 0.
  - Lower Term_Val to 3 while Cnt_Out = 10, WRAP -> the next enabled step gives Cnt_Out = 0 and TC_Evt = 1.
- Assert Rst_N low asynchronously mid-count between clock edges (Cnt_Out = 0x7A, RUN) -> Cnt_Out = 0, IDLE, Busy = 0, Done = 0 immediately; En_Cnt is ignored until Start_Pe.
- IDLE after reset with En_Cnt held high for 10 cycles -> Cnt_Out remains 0, CO reflects terminal (1 when down), TC_Evt stays 0.
